// File: rtl/clk_enable_gen.sv
// Fractional clock-enable generator: o_ce strobes at mul/div of i_clk via a
// drift-free accumulator. Optional toggle output o_clk under CLK_ENABLE_GEN_TOGGLE_EN.
module clk_enable_gen #(
  parameter int unsigned MULTIPLY_BY = 74,
  parameter int unsigned DIVIDE_BY   = 147,
  parameter int unsigned ACC_WIDTH   = 16,
  parameter int unsigned LOCK_CYCLES = 16
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_cfg_valid,
  input  logic [ACC_WIDTH-1:0] i_cfg_mul,
  input  logic [ACC_WIDTH-1:0] i_cfg_div,
  output logic                 o_cfg_ready,
  output logic                 o_cfg_err,
  output logic                 o_ce,
  output logic                 o_locked
`ifdef CLK_ENABLE_GEN_TOGGLE_EN
  ,
  output logic                 o_clk
`endif
);

  typedef enum logic [1:0] {RELOAD, SETTLE, LOCKED} state_t;

  localparam int unsigned CNT_W = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_CYCLES - 1);

  state_t               state, state_nx;
  logic [ACC_WIDTH-1:0] acc, acc_nx;
  logic [ACC_WIDTH-1:0] mul_q, mul_nx;
  logic [ACC_WIDTH-1:0] div_q, div_nx;
  logic [CNT_W-1:0]     cnt, cnt_nx;
  logic                 ce_q, ce_nx;
  logic                 err_q, err_nx;
  logic [ACC_WIDTH:0]   sum, diff;
  logic                 step_ce, transfer, cfg_bad;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state <= RELOAD;
      acc   <= '0;
      mul_q <= ACC_WIDTH'(MULTIPLY_BY);
      div_q <= ACC_WIDTH'(DIVIDE_BY);
      cnt   <= '0;
      ce_q  <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state <= state_nx;
      acc   <= acc_nx;
      mul_q <= mul_nx;
      div_q <= div_nx;
      cnt   <= cnt_nx;
      ce_q  <= ce_nx;
      err_q <= err_nx;
    end
  end

  always_comb begin
    sum      = {1'b0, acc} + {1'b0, mul_q};
    diff     = sum - {1'b0, div_q};
    step_ce  = (sum >= {1'b0, div_q});
    transfer = i_cfg_valid && (state != RELOAD);
    cfg_bad  = (i_cfg_div == '0) || (i_cfg_mul == '0) || (i_cfg_mul > i_cfg_div);

    state_nx = state;
    acc_nx   = acc;
    mul_nx   = mul_q;
    div_nx   = div_q;
    cnt_nx   = cnt;
    ce_nx    = 1'b0;
    err_nx   = 1'b0;

    case (state)
      RELOAD: begin
        state_nx = SETTLE;
        acc_nx   = '0;
        cnt_nx   = '0;
      end
      SETTLE, LOCKED: begin
        if (step_ce) begin
          acc_nx = diff[ACC_WIDTH-1:0];
          ce_nx  = 1'b1;
        end else begin
          acc_nx = sum[ACC_WIDTH-1:0];
        end
        // A valid ratio wins over everything, including the final SETTLE edge;
        // a rejected one leaves the strobe stepping but freezes state and lock count.
        if (transfer && !cfg_bad) begin
          mul_nx   = i_cfg_mul;
          div_nx   = i_cfg_div;
          state_nx = RELOAD;
          acc_nx   = '0;
          cnt_nx   = '0;
          ce_nx    = 1'b0;
        end else if (transfer) begin
          err_nx = 1'b1;
        end else if (state == SETTLE) begin
          if (cnt == CNT_LAST) state_nx = LOCKED;
          else                 cnt_nx   = cnt + 1'b1;
        end
      end
      default: state_nx = RELOAD;
    endcase
  end

  assign o_ce        = ce_q;
  assign o_cfg_err   = err_q;
  assign o_cfg_ready = (state != RELOAD);
  assign o_locked    = (state == LOCKED);

`ifdef CLK_ENABLE_GEN_TOGGLE_EN
  logic clk_q;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)      clk_q <= 1'b0;
    else if (ce_nx) clk_q <= ~clk_q;
  end

  assign o_clk = clk_q;
`endif

endmodule

// File: tb/tb_clk_enable_gen.sv
// Self-checking bench for clk_enable_gen: directed scenarios plus random ratio
// offers, checked against an arithmetic floor(n*mul/div) reference model.
module tb_clk_enable_gen;

  localparam int unsigned LOCK = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        cfg_valid;
  logic [15:0] cfg_mul, cfg_div;
  logic        cfg_ready, cfg_err, ce, locked;
`ifdef CLK_ENABLE_GEN_TOGGLE_EN
  logic        tclk;
`endif

  int checks   = 0;
  int failures = 0;

  // reference model: edges counted since leaving RELOAD and the latched ratio
  bit     m_reload;
  longint m_n, m_mul, m_div;
  bit     e_ce, e_err, e_clk;

  clk_enable_gen #(
    .MULTIPLY_BY(74),
    .DIVIDE_BY  (147),
    .ACC_WIDTH  (16),
    .LOCK_CYCLES(LOCK)
  ) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_cfg_valid(cfg_valid),
    .i_cfg_mul  (cfg_mul),
    .i_cfg_div  (cfg_div),
    .o_cfg_ready(cfg_ready),
    .o_cfg_err  (cfg_err),
    .o_ce       (ce),
    .o_locked   (locked)
`ifdef CLK_ENABLE_GEN_TOGGLE_EN
    ,
    .o_clk      (tclk)
`endif
  );

  always #5 clk = ~clk;

  function automatic bit rate_strobe(longint n);
    return ((n * m_mul) / m_div) > (((n - 1) * m_mul) / m_div);
  endfunction

  task automatic model_reset();
    m_reload = 1'b1;
    m_n      = 0;
    m_mul    = 74;
    m_div    = 147;
    e_ce     = 1'b0;
    e_err    = 1'b0;
    e_clk    = 1'b0;
  endtask

  // drive one edge of stimulus and advance the model; samples land 1ns after the edge
  task automatic step(input logic v, input logic [15:0] m, input logic [15:0] d);
    cfg_valid = v;
    cfg_mul   = m;
    cfg_div   = d;
    @(posedge clk);
    if (m_reload) begin
      m_reload = 1'b0;
      m_n      = 0;
      e_ce     = 1'b0;
      e_err    = 1'b0;
    end else if (v && (d == 0 || m == 0 || m > d)) begin
      e_err = 1'b1;
      m_n++;
      e_ce  = rate_strobe(m_n);
    end else if (v) begin
      m_mul    = m;
      m_div    = d;
      m_reload = 1'b1;
      e_ce     = 1'b0;
      e_err    = 1'b0;
    end else begin
      e_err = 1'b0;
      m_n++;
      e_ce  = rate_strobe(m_n);
    end
    if (e_ce) e_clk = ~e_clk;
    #1;
    cfg_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cfg_valid = 1'b0; cfg_mul = '0; cfg_div = '0;
    model_reset();
    #1;
    checks++; if (ce !== 1'b0)        begin failures++; $display("FAIL reset_ce: got %b exp 0", ce); end
    checks++; if (locked !== 1'b0)    begin failures++; $display("FAIL reset_locked: got %b exp 0", locked); end
    checks++; if (cfg_ready !== 1'b0) begin failures++; $display("FAIL reset_ready: got %b exp 0", cfg_ready); end
    checks++; if (cfg_err !== 1'b0)   begin failures++; $display("FAIL reset_err: got %b exp 0", cfg_err); end
    @(posedge clk); #1;
    checks++; if (cfg_ready !== 1'b0 || ce !== 1'b0) begin
      failures++; $display("FAIL reset_held: got ready=%b ce=%b exp 0 0", cfg_ready, ce);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_default_rate();
    int strobes = 0;
    int lock_edge = 0;
    for (int e = 1; e <= 1471; e++) begin
      step(1'b0, '0, '0);
      checks++; if (ce !== e_ce) begin failures++; $display("FAIL default_ce edge %0d: got %b exp %b", e, ce, e_ce); end
      checks++; if (locked !== (!m_reload && m_n >= LOCK)) begin
        failures++; $display("FAIL default_locked edge %0d: got %b exp %b", e, locked, (!m_reload && m_n >= LOCK));
      end
      if (e >= 2 && ce) strobes++;
      if (lock_edge == 0 && locked) lock_edge = e;
    end
    checks++; if (strobes != 740) begin failures++; $display("FAIL default_count: got %0d exp 740", strobes); end
    checks++; if (lock_edge != 17) begin failures++; $display("FAIL default_lock_edge: got %0d exp 17", lock_edge); end
  endtask

  task automatic test_half_rate();
    step(1'b1, 16'd1, 16'd2);
    checks++; if (locked !== 1'b0)    begin failures++; $display("FAIL half_unlock: got %b exp 0", locked); end
    checks++; if (cfg_ready !== 1'b0) begin failures++; $display("FAIL half_ready_reload: got %b exp 0", cfg_ready); end
    step(1'b0, '0, '0);
    for (int k = 1; k <= 20; k++) begin
      step(1'b0, '0, '0);
      checks++; if (ce !== ((k % 2) == 0)) begin
        failures++; $display("FAIL half_ce settle %0d: got %b exp %b", k, ce, ((k % 2) == 0));
      end
      checks++; if (locked !== (k >= 16)) begin
        failures++; $display("FAIL half_locked settle %0d: got %b exp %b", k, locked, (k >= 16));
      end
    end
  endtask

  task automatic test_invalid();
    int errs = 0;
    for (int k = 1; k <= 12; k++) begin
      if (k == 1)      step(1'b1, 16'd5, 16'd3);
      else if (k == 4) step(1'b1, 16'd1, 16'd0);
      else             step(1'b0, '0, '0);
      checks++; if (cfg_err !== e_err) begin failures++; $display("FAIL invalid_err step %0d: got %b exp %b", k, cfg_err, e_err); end
      checks++; if (locked !== 1'b1)   begin failures++; $display("FAIL invalid_locked step %0d: got %b exp 1", k, locked); end
      checks++; if (ce !== e_ce)       begin failures++; $display("FAIL invalid_ce step %0d: got %b exp %b", k, ce, e_ce); end
      if (cfg_err) errs++;
    end
    checks++; if (errs != 2) begin failures++; $display("FAIL invalid_pulses: got %0d exp 2", errs); end
  endtask

  task automatic test_unity();
    step(1'b1, 16'd8, 16'd8);
    step(1'b0, '0, '0);
    for (int k = 1; k <= 30; k++) begin
      step(1'b0, '0, '0);
      checks++; if (ce !== 1'b1) begin failures++; $display("FAIL unity_ce settle %0d: got %b exp 1", k, ce); end
    end
  endtask

`ifdef CLK_ENABLE_GEN_TOGGLE_EN
  task automatic test_toggle();
    int highs = 0;
    step(1'b1, 16'd1, 16'd2);
    step(1'b0, '0, '0);
    for (int k = 1; k <= 40; k++) begin
      step(1'b0, '0, '0);
      checks++; if (tclk !== e_clk) begin failures++; $display("FAIL toggle_clk settle %0d: got %b exp %b", k, tclk, e_clk); end
      if (tclk) highs++;
    end
    checks++; if (highs != 20) begin failures++; $display("FAIL toggle_duty: got %0d exp 20", highs); end
  endtask
`endif

  task automatic test_mid_reset();
    int lock_edge = 0;
    step(1'b1, 16'd3, 16'd7);
    step(1'b0, '0, '0);
    for (int k = 1; k <= 4; k++) begin
      step(1'b0, '0, '0);
      checks++; if (cfg_ready !== 1'b1) begin failures++; $display("FAIL midrst_ready settle %0d: got %b exp 1", k, cfg_ready); end
    end
    cfg_valid = 1'b1; cfg_mul = 16'd1; cfg_div = 16'd2;
    #2;
    rst = 1'b1;
    #1;
    checks++; if ({ce, locked, cfg_ready, cfg_err} !== 4'b0000) begin
      failures++; $display("FAIL midrst_outputs: got %b exp 0000", {ce, locked, cfg_ready, cfg_err});
    end
    cfg_valid = 1'b0;
    model_reset();
    @(posedge clk); #1;
    @(negedge clk);
    rst = 1'b0;
    for (int e = 1; e <= 200; e++) begin
      step(1'b0, '0, '0);
      checks++; if (ce !== e_ce) begin failures++; $display("FAIL midrst_ce edge %0d: got %b exp %b", e, ce, e_ce); end
      if (lock_edge == 0 && locked) lock_edge = e;
    end
    checks++; if (lock_edge != 17) begin failures++; $display("FAIL midrst_lock_edge: got %0d exp 17", lock_edge); end
  endtask

  task automatic test_random();
    logic        v;
    logic [15:0] m, d;
    for (int k = 0; k < 1500; k++) begin
      v = 1'b0; m = '0; d = '0;
      if ($urandom_range(0, 19) == 0) begin
        v = 1'b1;
        if (!m_reload && m_n >= LOCK && $urandom_range(0, 2) == 0) begin
          case ($urandom_range(0, 2))
            0:       begin m = '0; d = 16'($urandom_range(1, 40)); end
            1:       begin d = '0; m = 16'($urandom_range(1, 40)); end
            default: begin d = 16'($urandom_range(1, 30)); m = d + 16'($urandom_range(1, 5)); end
          endcase
        end else begin
          d = 16'($urandom_range(1, 40));
          m = 16'($urandom_range(1, d));
        end
      end
      step(v, m, d);
      checks++; if (ce !== e_ce)   begin failures++; $display("FAIL rand_ce %0d: got %b exp %b", k, ce, e_ce); end
      checks++; if (cfg_err !== e_err) begin failures++; $display("FAIL rand_err %0d: got %b exp %b", k, cfg_err, e_err); end
      checks++; if (cfg_ready !== !m_reload) begin failures++; $display("FAIL rand_ready %0d: got %b exp %b", k, cfg_ready, !m_reload); end
      checks++; if (locked !== (!m_reload && m_n >= LOCK)) begin
        failures++; $display("FAIL rand_locked %0d: got %b exp %b", k, locked, (!m_reload && m_n >= LOCK));
      end
    end
  endtask

  initial begin
    test_reset();
    test_default_rate();
    test_half_rate();
    test_invalid();
    test_unity();
`ifdef CLK_ENABLE_GEN_TOGGLE_EN
    test_toggle();
`endif
    test_mid_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
